// File: rtl/l2_req_arbiter.sv
// L2 request arbiter: shares one L2 request port among per-thread L1 buffers.
// Global class priority (refill > branch > sequential) with round-robin between threads.
module l2_req_arbiter #(
    parameter int NTHREAD = 4,
    parameter int TIMEOUT = 64,
    localparam int TID_W = $clog2(NTHREAD),
    localparam int WD_W  = $clog2(TIMEOUT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NTHREAD-1:0]     req_refill,
    input  logic [NTHREAD-1:0]     req_br,
    input  logic [NTHREAD-1:0]     req_spec,
    input  logic [NTHREAD*32-1:0]  refill_addr,
    input  logic [NTHREAD*32-1:0]  br_addr,
    input  logic [NTHREAD*32-1:0]  spec_addr,
    output logic                   l2_req_valid,
    input  logic                   l2_req_ready,
    output logic [31:0]            l2_req_addr,
    output logic [TID_W-1:0]       l2_req_tid,
    output logic [1:0]             l2_req_kind,
    input  logic                   l2_rsp_valid,
    input  logic [TID_W-1:0]       l2_rsp_tid,
    output logic [NTHREAD-1:0]     busy,
    output logic                   rsp_err,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_QUEUED = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    localparam logic [1:0] KIND_REFILL = 2'd0;
    localparam logic [1:0] KIND_BR     = 2'd1;
    localparam logic [1:0] KIND_SPEC   = 2'd2;

    state_e             state_r     [NTHREAD];
    state_e             state_nxt_s [NTHREAD];
    logic [WD_W-1:0]    wdog_r      [NTHREAD];
    logic [WD_W-1:0]    wdog_nxt_s  [NTHREAD];
    logic [27:0]        last_line_r [NTHREAD];
    logic [TID_W-1:0]   rr_ptr_r;
    logic               held_s;
    logic               hs_s;
    logic [NTHREAD-1:0] refill_v_s;
    logic [NTHREAD-1:0] br_v_s;
    logic [NTHREAD-1:0] spec_v_s;
    logic [NTHREAD-1:0] cls_v_s;
    logic [1:0]         cls_kind_s;
    logic               grant_s;
    logic [TID_W-1:0]   win_tid_s;
    logic [31:0]        sel_addr_s;
    logic               rsp_stray_s;
    logic               wdog_fire_s;
    logic               unused_nib_s;

    assign hs_s         = l2_req_valid && l2_req_ready;
    assign held_s       = l2_req_valid && !l2_req_ready;
    assign unused_nib_s = ^sel_addr_s[3:0];

    // Effective requests per class; prefetches to the last issued line are suppressed.
    always_comb begin
        refill_v_s = '0;
        br_v_s     = '0;
        spec_v_s   = '0;
        for (int t = 0; t < NTHREAD; t++) begin
            if (state_r[t] == ST_IDLE && !held_s) begin
                refill_v_s[t] = req_refill[t];
                br_v_s[t]     = req_br[t] && (br_addr[32*t+4 +: 28] != last_line_r[t]);
                spec_v_s[t]   = req_spec[t] && (spec_addr[32*t+4 +: 28] != last_line_r[t]);
            end else begin
                refill_v_s[t] = 1'b0;
                br_v_s[t]     = 1'b0;
                spec_v_s[t]   = 1'b0;
            end
        end
    end

    // Pick the winning class, then round-robin from the pointer within it.
    always_comb begin
        int idx;
        idx        = 0;
        cls_v_s    = spec_v_s;
        cls_kind_s = KIND_SPEC;
        if (|refill_v_s) begin
            cls_v_s    = refill_v_s;
            cls_kind_s = KIND_REFILL;
        end else if (|br_v_s) begin
            cls_v_s    = br_v_s;
            cls_kind_s = KIND_BR;
        end else begin
            cls_v_s    = spec_v_s;
            cls_kind_s = KIND_SPEC;
        end
        grant_s   = 1'b0;
        win_tid_s = '0;
        for (int i = 0; i < NTHREAD; i++) begin
            idx = (int'(rr_ptr_r) + i) % NTHREAD;
            if (!grant_s && cls_v_s[idx]) begin
                grant_s   = 1'b1;
                win_tid_s = TID_W'(idx);
            end else begin
                grant_s   = grant_s;
                win_tid_s = win_tid_s;
            end
        end
        case (cls_kind_s)
            KIND_REFILL: sel_addr_s = refill_addr[32*int'(win_tid_s) +: 32];
            KIND_BR:     sel_addr_s = br_addr[32*int'(win_tid_s) +: 32];
            KIND_SPEC:   sel_addr_s = spec_addr[32*int'(win_tid_s) +: 32];
            default:     sel_addr_s = refill_addr[32*int'(win_tid_s) +: 32];
        endcase
    end

    // Per-thread next state and watchdog; a response outside WAIT is flagged as stray.
    always_comb begin
        rsp_stray_s = l2_rsp_valid;
        wdog_fire_s = 1'b0;
        for (int t = 0; t < NTHREAD; t++) begin
            state_nxt_s[t] = state_r[t];
            wdog_nxt_s[t]  = wdog_r[t];
            case (state_r[t])
                ST_IDLE: begin
                    if (grant_s && win_tid_s == TID_W'(t)) begin
                        state_nxt_s[t] = ST_QUEUED;
                    end else begin
                        state_nxt_s[t] = ST_IDLE;
                    end
                end
                ST_QUEUED: begin
                    if (hs_s && l2_req_tid == TID_W'(t)) begin
                        state_nxt_s[t] = ST_WAIT;
                        wdog_nxt_s[t]  = '0;
                    end else begin
                        state_nxt_s[t] = ST_QUEUED;
                    end
                end
                ST_WAIT: begin
                    if (l2_rsp_valid && l2_rsp_tid == TID_W'(t)) begin
                        state_nxt_s[t] = ST_IDLE;
                        wdog_nxt_s[t]  = '0;
                        rsp_stray_s    = 1'b0;
                    end else if (wdog_r[t] == WD_W'(TIMEOUT-1)) begin
                        state_nxt_s[t] = ST_IDLE;
                        wdog_nxt_s[t]  = '0;
                        wdog_fire_s    = 1'b1;
                    end else begin
                        wdog_nxt_s[t]  = wdog_r[t] + WD_W'(1);
                    end
                end
                default: begin
                    state_nxt_s[t] = ST_IDLE;
                    wdog_nxt_s[t]  = '0;
                end
            endcase
        end
    end

    // Thread state, dedup lines, round-robin pointer and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < NTHREAD; t++) begin
                state_r[t]     <= ST_IDLE;
                wdog_r[t]      <= '0;
                last_line_r[t] <= '0;
            end
            rr_ptr_r     <= '0;
            l2_req_valid <= 1'b0;
            l2_req_addr  <= 32'h0;
            l2_req_tid   <= '0;
            l2_req_kind  <= 2'd0;
            busy         <= '0;
            rsp_err      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            for (int t = 0; t < NTHREAD; t++) begin
                state_r[t] <= state_nxt_s[t];
                wdog_r[t]  <= wdog_nxt_s[t];
                busy[t]    <= (state_nxt_s[t] != ST_IDLE);
                if (hs_s && l2_req_tid == TID_W'(t)) begin
                    last_line_r[t] <= l2_req_addr[31:4];
                end else begin
                    last_line_r[t] <= last_line_r[t];
                end
            end
            if (grant_s) begin
                l2_req_valid <= 1'b1;
                l2_req_addr  <= {sel_addr_s[31:4], 4'h0};
                l2_req_tid   <= win_tid_s;
                l2_req_kind  <= cls_kind_s;
                rr_ptr_r     <= (win_tid_s == TID_W'(NTHREAD-1)) ? '0 : win_tid_s + TID_W'(1);
            end else if (hs_s) begin
                l2_req_valid <= 1'b0;
            end else begin
                l2_req_valid <= l2_req_valid;
            end
            rsp_err     <= rsp_err | rsp_stray_s;
            timeout_err <= timeout_err | wdog_fire_s;
        end
    end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: scoreboard of expected L2 requests
// popped on each handshake, plus direct checks of state and error flags.
module tb_l2_req_arbiter;

    localparam int NT = 4;

    logic            clk;
    logic            reset;
    logic [NT-1:0]   req_refill;
    logic [NT-1:0]   req_br;
    logic [NT-1:0]   req_spec;
    logic [NT*32-1:0] refill_addr;
    logic [NT*32-1:0] br_addr;
    logic [NT*32-1:0] spec_addr;
    logic            l2_req_valid;
    logic            l2_req_ready;
    logic [31:0]     l2_req_addr;
    logic [1:0]      l2_req_tid;
    logic [1:0]      l2_req_kind;
    logic            l2_rsp_valid;
    logic [1:0]      l2_rsp_tid;
    logic [NT-1:0]   busy;
    logic            rsp_err;
    logic            timeout_err;

    typedef struct packed {
        logic [1:0]  tid;
        logic [1:0]  kind;
        logic [31:0] addr;
    } req_t;

    req_t       exp_q [$];
    logic [1:0] wait_q [$];
    int         n_checks = 0;
    int         n_errors = 0;

    l2_req_arbiter #(.NTHREAD(NT), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req_refill(req_refill), .req_br(req_br), .req_spec(req_spec),
        .refill_addr(refill_addr), .br_addr(br_addr), .spec_addr(spec_addr),
        .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
        .l2_req_addr(l2_req_addr), .l2_req_tid(l2_req_tid), .l2_req_kind(l2_req_kind),
        .l2_rsp_valid(l2_rsp_valid), .l2_rsp_tid(l2_rsp_tid),
        .busy(busy), .rsp_err(rsp_err), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_req(input logic [1:0] tid, input logic [1:0] kind, input logic [31:0] addr);
        req_t e;
        e.tid  = tid;
        e.kind = kind;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic respond(input logic [1:0] tid);
        l2_rsp_valid = 1'b1;
        l2_rsp_tid   = tid;
        tick();
        l2_rsp_valid = 1'b0;
    endtask

    // One cycle of the round-robin test: answer the oldest accepted request, if any.
    task automatic rr_cycle();
        if (wait_q.size() > 0) begin
            l2_rsp_valid = 1'b1;
            l2_rsp_tid   = wait_q.pop_front();
        end else begin
            l2_rsp_valid = 1'b0;
        end
        tick();
    endtask

    // Scoreboard: every handshake must match the oldest expected request.
    always @(negedge clk) begin
        if (reset && l2_req_valid && l2_req_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_req", 64'd1, 64'd0);
            end else begin
                req_t e;
                e = exp_q.pop_front();
                check("sb_tid", l2_req_tid, e.tid);
                check("sb_kind", l2_req_kind, e.kind);
                check("sb_addr", l2_req_addr, e.addr);
            end
            wait_q.push_back(l2_req_tid);
        end
    end

    initial begin
        reset        = 1'b0;
        req_refill   = '0;
        req_br       = '0;
        req_spec     = '0;
        refill_addr  = '0;
        br_addr      = '0;
        spec_addr    = '0;
        l2_req_ready = 1'b0;
        l2_rsp_valid = 1'b0;
        l2_rsp_tid   = 2'd0;
        tick();
        tick();
        check("rst_valid", l2_req_valid, 1'b0);
        check("rst_addr", l2_req_addr, 32'h0);
        check("rst_tid", l2_req_tid, 2'd0);
        check("rst_kind", l2_req_kind, 2'd0);
        check("rst_busy", busy, 4'b0000);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        reset = 1'b1;
        tick();

        // Single refill on thread 2
        l2_req_ready = 1'b1;
        req_refill[2] = 1'b1;
        refill_addr[64 +: 32] = 32'h0000_1234;
        expect_req(2'd2, 2'd0, 32'h0000_1230);
        tick();
        check("t1_valid", l2_req_valid, 1'b1);
        check("t1_busy_queued", busy, 4'b0100);
        req_refill[2] = 1'b0;
        tick();
        check("t1_valid_drop", l2_req_valid, 1'b0);
        check("t1_busy_wait", busy, 4'b0100);
        respond(2'd2);
        check("t1_busy_released", busy, 4'b0000);
        check("t1_rsp_err", rsp_err, 1'b0);

        // Class priority across threads, back-to-back issue
        req_spec[0] = 1'b1;
        spec_addr[0 +: 32] = 32'h0000_0200;
        req_br[1] = 1'b1;
        br_addr[32 +: 32] = 32'h0000_0300;
        req_refill[3] = 1'b1;
        refill_addr[96 +: 32] = 32'h0000_0400;
        expect_req(2'd3, 2'd0, 32'h0000_0400);
        expect_req(2'd1, 2'd1, 32'h0000_0300);
        expect_req(2'd0, 2'd2, 32'h0000_0200);
        tick();
        req_refill[3] = 1'b0;
        tick();
        check("pri_b2b_valid", l2_req_valid, 1'b1);
        tick();
        tick();
        check("pri_valid_idle", l2_req_valid, 1'b0);
        check("pri_busy", busy, 4'b1011);
        respond(2'd0);
        respond(2'd1);
        respond(2'd3);
        // Prefetches to the same lines stay held: they must not reissue
        tick();
        tick();
        tick();
        check("dedup_valid", l2_req_valid, 1'b0);
        check("dedup_busy", busy, 4'b0000);
        check("dedup_rsp_err", rsp_err, 1'b0);
        req_br[1] = 1'b0;
        spec_addr[0 +: 32] = 32'h0000_0218;
        expect_req(2'd0, 2'd2, 32'h0000_0210);
        tick();
        check("newline_valid", l2_req_valid, 1'b1);
        req_spec[0] = 1'b0;
        tick();
        respond(2'd0);
        check("newline_busy", busy, 4'b0000);

        // Round-robin: last grant was thread 0, so the pointer sits at 1
        wait_q.delete();
        for (int t = 0; t < NT; t++) begin
            refill_addr[32*t +: 32] = 32'h1000 * (t + 1) + 32'h5;
        end
        for (int k = 0; k < 5; k++) begin
            int w;
            w = (1 + k) % NT;
            expect_req(2'(w), 2'd0, 32'h1000 * (w + 1));
        end
        req_refill = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            rr_cycle();
        end
        req_refill = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            rr_cycle();
        end
        check("rr_drain_busy", busy, 4'b0000);
        check("rr_drain_valid", l2_req_valid, 1'b0);
        check("rr_sb_empty", exp_q.size(), 0);

        // Backpressure: fields hold while the requester changes its address
        l2_req_ready = 1'b0;
        req_refill[1] = 1'b1;
        refill_addr[32 +: 32] = 32'h0000_5555;
        expect_req(2'd1, 2'd0, 32'h0000_5550);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", l2_req_valid, 1'b1);
            check("bp_addr", l2_req_addr, 32'h0000_5550);
            check("bp_tid", l2_req_tid, 2'd1);
            check("bp_kind", l2_req_kind, 2'd0);
            refill_addr[32 +: 32] = 32'h0000_9990 + 32'h100 * k;
            tick();
        end
        l2_req_ready = 1'b1;
        req_refill[1] = 1'b0;
        tick();
        check("bp_valid_drop", l2_req_valid, 1'b0);
        check("bp_busy_wait", busy, 4'b0010);

        // Watchdog: with TIMEOUT=8 the thread leaves WAIT on the 8th WAIT cycle
        repeat (7) tick();
        check("wd_busy_before", busy, 4'b0010);
        check("wd_err_before", timeout_err, 1'b0);
        tick();
        check("wd_busy_after", busy, 4'b0000);
        check("wd_err_after", timeout_err, 1'b1);

        // Async reset drops a held request; a later response is stray
        l2_req_ready = 1'b0;
        req_refill[0] = 1'b1;
        refill_addr[0 +: 32] = 32'h0000_7770;
        tick();
        check("rst2_held_valid", l2_req_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("rst2_valid", l2_req_valid, 1'b0);
        check("rst2_busy", busy, 4'b0000);
        check("rst2_timeout_err", timeout_err, 1'b0);
        req_refill[0] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst2_rsp_err_clear", rsp_err, 1'b0);
        respond(2'd1);
        check("stray_rsp_err", rsp_err, 1'b1);
        check("stray_busy", busy, 4'b0000);
        tick();
        check("stray_rsp_err_sticky", rsp_err, 1'b1);
        check("final_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/l2_req_arbiter.md
Name: l2_req_arbiter

Overview:
- Shares the single L2 request port among the per-thread L1 cache buffers of the interleaved-multithreading core.
- Each thread's buffer raises level-sensitive refill, branch-prefetch and sequential-prefetch requests. The arbiter picks one request per handshake, using fixed class priority and round-robin order between threads.
- It tracks one outstanding L2 transaction per thread and suppresses duplicate prefetches.
- It releases a thread when an L2 response tagged with that thread's ID returns, or when a watchdog expires.

Parameters:
- NTHREAD, 4, number of hardware threads/requesters; TID_bits = $clog2(NTHREAD).
- TIMEOUT, 64, cycles a thread may wait for an L2 response before forced release; must be ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_refill  in  NTHREAD  per-thread demand-miss request (level)
- req_br  in  NTHREAD  per-thread branch-target prefetch request (level)
- req_spec  in  NTHREAD  per-thread next-line prefetch request (level)
- refill_addr  in  NTHREAD*32  per-thread miss address, thread t at [32t+:32]
- br_addr  in  NTHREAD*32  per-thread branch target address
- spec_addr  in  NTHREAD*32  per-thread next-line address
- l2_req_valid  out  1  request to L2 valid
- l2_req_ready  in  1  L2 accepts request
- l2_req_addr  out  32  line address, bits [3:0] forced to 0
- l2_req_tid  out  TID_bits  requesting thread
- l2_req_kind  out  2  request kind: 0 = refill, 1 = branch prefetch, 2 = sequential prefetch
- l2_rsp_valid  in  1  L2 line response valid
- l2_rsp_tid  in  TID_bits  thread ID of the response
- busy  out  NTHREAD  thread has a transaction queued or outstanding
- rsp_err  out  1  sticky: response arrived for a non-WAIT thread
- timeout_err  out  1  sticky: watchdog fired

Behaviour:
- Reset (reset=0, async): every output is 0, all threads IDLE, RR pointer = 0, every last_line[t] = 0, every watchdog = 0.
- Per-thread state machine:
  - IDLE → QUEUED when the thread wins arbitration.
  - QUEUED → WAIT on the l2_req_valid && l2_req_ready handshake.
  - WAIT → IDLE on l2_rsp_valid && l2_rsp_tid==t, or when the watchdog reaches TIMEOUT-1.
- Eligibility: thread is IDLE, no request currently held in the output register, and at least one effective request.
- Effective request:
  - refill: req_refill[t].
  - br: req_br[t] && br_addr[31:4] != last_line[t].
  - spec: req_spec[t] && spec_addr[31:4] != last_line[t].
- Class priority is global: refill > br > spec. Any eligible refill beats every br; any br beats every spec. A thread presents only its highest class.
- Within the winning class, round-robin starts at the RR pointer. On grant the pointer becomes (winner+1) mod NTHREAD.
- Grant latency: the winner is registered onto l2_req_* one cycle after eligibility is evaluated. Fields are addr={sel_addr[31:4],4'h0}, tid=winner, kind.
- Handshake rules:
  - While l2_req_valid=1 && l2_req_ready=0, all l2_req_* hold stable, even if the requester deasserts.
  - On handshake: l2_req_valid drops the next cycle unless a new grant is loaded in the same edge; back-to-back issue is allowed, so throughput is one request per cycle.
  - On handshake: last_line[winner] ← addr[31:4], and the watchdog is cleared.
- Watchdog: counts each cycle in WAIT. At TIMEOUT-1 it forces IDLE and sets timeout_err.
- A response to a thread not in WAIT is ignored for state and sets rsp_err.
- Simultaneous response and eligibility for the same thread: the thread frees at the edge and is not eligible in that same cycle; it is eligible from the next cycle.
- A refill whose line equals last_line[t] is still issued; last_line dedup applies only to prefetch classes.
- busy[t] = (state[t] != IDLE).
- Asynchronous reset mid-transaction drops any held request immediately (l2_req_valid=0). Responses arriving after reset set rsp_err.

Test Plan:
- Single refill, NTHREAD=4: req_refill[2]=1, refill_addr[2]=0x0000_1234, ready=1 → next cycle l2_req_valid=1, addr=0x0000_1230, tid=2, kind=0; busy[2]=1 until rsp_valid with tid=2, IDLE the following cycle.
- Priority: t0 req_spec, t1 req_br, t3 req_refill in the same cycle → order of issue t3/kind0, then t1/kind1, then t0/kind2, each after its predecessor's response returns or without waiting, since the threads differ.
- Round-robin: all four threads hold req_refill, with a response every cycle → grants 0,1,2,3,0; the pointer wraps correctly.
- Backpressure: grant t1 with ready=0 for 5 cycles while the requester changes refill_addr → l2_req_addr/tid/kind are unchanged, and the handshake fires on cycle 6.
- Dedup and timeout:
  - t0 req_spec held with spec_addr=0x100 after its response → no second issue.
  - With TIMEOUT=8 and no response, t0 returns to IDLE after 8 cycles and timeout_err=1.
- Reset with a held request plus a stray response: assert reset while valid=1 → l2_req_valid=0 immediately; a later l2_rsp_valid for tid=1 sets rsp_err=1.
